trojan5_decode_collector: RTL and testbench

Downstream consumer of the one-hot decoder stage. Samples each valid 16-bit decoded word together with the program-address tag and re-encodes it to a 4-bit index with one-hot integrity flags. Buffers results in a small first-word-fall-through FIFO and presents them on a valid/ready port. Records overflow drops with a sticky flag and a saturating counter.

---
 rtl/trojan5_decode_collector.sv | 108 ++++++++++
 tb/tb_trojan5_decode_collector.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/trojan5_decode_collector.sv
// Re-encodes each valid one-hot decoder word to an index with integrity flags and
// queues the result with its address tag in a small FWFT FIFO; overflow drops are counted.
module trojan5_decode_collector #(
    parameter int  FIFO_DEPTH = 4,
    parameter int  ADDR_W     = 13,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              pon_rst_i,
    input  logic [15:0]       decoded_output_i,
    input  logic              decode_valid_i,
    input  logic [ADDR_W-1:0] prog_adr_i,
    input  logic              res_ready_i,
    output logic              res_valid_o,
    output logic [3:0]        res_index_o,
    output logic              res_onehot_ok_o,
    output logic              res_zero_o,
    output logic [ADDR_W-1:0] res_adr_o,
    output logic [LVL_W-1:0]  fifo_level_o,
    output logic              overflow_o,
    output logic [7:0]        drop_count_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = ADDR_W + 6;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_overflow;
    logic [7:0]       r_drop_count;
    logic [ENT_W-1:0] r_mem [FIFO_DEPTH];

    logic [3:0]       w_index;
    logic [4:0]       w_ones;
    logic [ENT_W-1:0] w_entry;
    logic [ENT_W-1:0] w_head;
    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // Scanning from the top down lets the lowest set bit win the index.
    always_comb begin
        w_index = 4'd0;
        w_ones  = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (decoded_output_i[i]) begin
                w_index = 4'(i);
            end
            w_ones = w_ones + 5'(decoded_output_i[i]);
        end
    end

    assign w_entry = {prog_adr_i, (w_ones == 5'd0), (w_ones == 5'd1), w_index};

    assign w_valid = (r_level != '0);
    assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_pop   = w_valid && res_ready_i;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign w_push  = decode_valid_i && (!w_full || w_pop);
    assign w_drop  = decode_valid_i && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or posedge pon_rst_i) begin
        if (pon_rst_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
        end
    end

    // Storage is not reset, so head fields are masked to zero while empty.
    assign w_head          = r_mem[r_rd_ptr];
    assign res_valid_o     = w_valid;
    assign res_index_o     = w_valid ? w_head[3:0] : 4'd0;
    assign res_onehot_ok_o = w_valid && w_head[4];
    assign res_zero_o      = w_valid && w_head[5];
    assign res_adr_o       = w_valid ? w_head[ENT_W-1:6] : '0;
    assign fifo_level_o    = r_level;
    assign overflow_o      = r_overflow;
    assign drop_count_o    = r_drop_count;
endmodule

// File: tb/tb_trojan5_decode_collector.sv
// Bench for trojan5_decode_collector: queue-based reference model compared every
// negative edge, plus literal expectations for the directed scenarios.
module tb_trojan5_decode_collector;
    logic        clk = 1'b0;
    logic        pon_rst_i;
    logic [15:0] decoded_output_i;
    logic        decode_valid_i;
    logic [12:0] prog_adr_i;
    logic        res_ready_i;
    logic        res_valid_o;
    logic [3:0]  res_index_o;
    logic        res_onehot_ok_o;
    logic        res_zero_o;
    logic [12:0] res_adr_o;
    logic [2:0]  fifo_level_o;
    logic        overflow_o;
    logic [7:0]  drop_count_o;

    int n_cmp  = 0;
    int n_fail = 0;

    trojan5_decode_collector #(.FIFO_DEPTH(4), .ADDR_W(13)) dut (
        .clk              (clk),
        .pon_rst_i        (pon_rst_i),
        .decoded_output_i (decoded_output_i),
        .decode_valid_i   (decode_valid_i),
        .prog_adr_i       (prog_adr_i),
        .res_ready_i      (res_ready_i),
        .res_valid_o      (res_valid_o),
        .res_index_o      (res_index_o),
        .res_onehot_ok_o  (res_onehot_ok_o),
        .res_zero_o       (res_zero_o),
        .res_adr_o        (res_adr_o),
        .fifo_level_o     (fifo_level_o),
        .overflow_o       (overflow_o),
        .drop_count_o     (drop_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a queue of raw captured words with their tags.
    typedef struct packed {
        logic [12:0] adr;
        logic [15:0] word;
    } ent_t;

    ent_t mq[$];
    bit   m_ovf;
    int   m_drops;
    bit   m_pop;
    bit   m_push;

    function automatic int low_bit(input logic [15:0] w);
        int r = 0;
        bit found = 0;
        for (int i = 0; i < 16; i++) begin
            if (!found && w[i]) begin
                r = i;
                found = 1;
            end
        end
        return r;
    endfunction

    always @(posedge clk or posedge pon_rst_i) begin
        if (pon_rst_i) begin
            mq.delete();
            m_ovf   = 0;
            m_drops = 0;
        end else begin
            m_pop  = (mq.size() != 0) && res_ready_i;
            m_push = decode_valid_i && (mq.size() < 4 || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back('{adr: prog_adr_i, word: decoded_output_i});
            else if (decode_valid_i) begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
        end
    end

    always @(negedge clk) begin
        check("valid", res_valid_o, (mq.size() != 0));
        check("level", fifo_level_o, mq.size());
        check("overflow", overflow_o, m_ovf);
        check("drops", drop_count_o, m_drops);
        if (pon_rst_i) begin
            check("rst_fields", {res_index_o, res_onehot_ok_o, res_zero_o, res_adr_o}, 0);
        end else if (mq.size() != 0) begin
            check("index", res_index_o, low_bit(mq[0].word));
            check("ok", res_onehot_ok_o, ($countones(mq[0].word) == 1));
            check("zero", res_zero_o, (mq[0].word == 16'h0));
            check("adr", res_adr_o, mq[0].adr);
        end
    end

    task automatic drive(input logic v, input logic [15:0] w, input logic [12:0] a, input logic rdy);
        decode_valid_i   = v;
        decoded_output_i = w;
        prog_adr_i       = a;
        res_ready_i      = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [12:0] drain_exp [4];
        logic [15:0] w;
        drain_exp[0] = 13'd2; drain_exp[1] = 13'd3; drain_exp[2] = 13'd4; drain_exp[3] = 13'd7;
        pon_rst_i = 1'b1;
        decode_valid_i = 1'b0; decoded_output_i = 16'h0; prog_adr_i = 13'h0; res_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 pon_rst_i = 1'b0;
        check("post_rst_level", fifo_level_o, 0);
        check("post_rst_valid", res_valid_o, 0);

        // Single pulse, then pop.
        drive(1, 16'h0008, 13'h012, 0);
        check("t1_valid", res_valid_o, 1);
        check("t1_index", res_index_o, 3);
        check("t1_ok", res_onehot_ok_o, 1);
        check("t1_zero", res_zero_o, 0);
        check("t1_adr", res_adr_o, 13'h012);
        check("t1_level", fifo_level_o, 1);
        drive(0, 16'h0, 13'h0, 1);
        check("t1_pop_level", fifo_level_o, 0);
        check("t1_pop_valid", res_valid_o, 0);

        // Zero, top one-hot and multi-hot words in order.
        drive(1, 16'h0000, 13'd1, 0);
        drive(1, 16'h8000, 13'd2, 0);
        drive(1, 16'h0120, 13'd3, 0);
        drive(0, 16'h0, 13'h0, 0);
        check("t2a", {res_index_o, res_onehot_ok_o, res_zero_o}, {4'd0, 1'b0, 1'b1});
        drive(0, 16'h0, 13'h0, 1);
        check("t2b", {res_index_o, res_onehot_ok_o, res_zero_o}, {4'd15, 1'b1, 1'b0});
        drive(0, 16'h0, 13'h0, 1);
        check("t2c", {res_index_o, res_onehot_ok_o, res_zero_o}, {4'd5, 1'b0, 1'b0});
        drive(0, 16'h0, 13'h0, 1);
        check("t2_empty", fifo_level_o, 0);

        // Overflow with six pushes, then push while popping on a full FIFO.
        for (int i = 1; i <= 6; i++) drive(1, 16'h0001, 13'(i), 0);
        check("t3_level", fifo_level_o, 4);
        check("t3_ovf", overflow_o, 1);
        check("t3_drops", drop_count_o, 2);
        check("t3_head", res_adr_o, 13'd1);
        drive(1, 16'h0002, 13'd7, 1);
        check("t3_pp_level", fifo_level_o, 4);
        check("t3_pp_drops", drop_count_o, 2);
        for (int i = 0; i < 4; i++) begin
            check("t3_drain", res_adr_o, drain_exp[i]);
            drive(0, 16'h0, 13'h0, 1);
        end
        check("t3_drained", fifo_level_o, 0);

        // Saturation, then asynchronous reset mid-stream.
        for (int i = 0; i < 300; i++) drive(1, 16'h0004, 13'(i), 0);
        check("t4_drops", drop_count_o, 255);
        check("t4_ovf", overflow_o, 1);
        #2 pon_rst_i = 1'b1;
        #1;
        check("t4_rst_now", {res_valid_o, res_index_o, res_onehot_ok_o, res_zero_o, res_adr_o,
                             fifo_level_o, overflow_o, drop_count_o}, 0);
        @(posedge clk);
        #1 pon_rst_i = 1'b0;
        decode_valid_i = 1'b0;
        drive(0, 16'h0, 13'h0, 0);
        check("t4_after_level", fifo_level_o, 0);
        check("t4_after_drops", drop_count_o, 0);

        // Streaming every one-hot position with the consumer always ready.
        for (int k = 0; k < 16; k++) begin
            drive(1, 16'h1 << k, 13'(k + 100), 1);
            check("t5_index", res_index_o, k);
            check("t5_level", fifo_level_o, 1);
        end
        drive(0, 16'h0, 13'h0, 1);
        check("t5_empty", fifo_level_o, 0);

        // Randomized traffic, compared by the model process every cycle.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       w = 16'h0;
                1:       w = 16'h1 << $urandom_range(0, 15);
                default: w = 16'($urandom);
            endcase
            drive(($urandom_range(0, 9) < 7), w, 13'($urandom),
                  (i % 400 < 100) ? 1'b0 : 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
